// File: rtl/line_bus_if.sv
// Requester-side and memory-side signals of line_bus_arbiter.
// slave is the arbiter's view; master is the requesters plus memory model driving it.
interface line_bus_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_BITS = 16,
  parameter int LINE_SIZE = 256
);
  logic [NUM_PORTS-1:0]           req_i;
  logic [NUM_PORTS-1:0]           wr_i;
  logic [NUM_PORTS*ADDR_BITS-1:0] addr_i;
  logic [NUM_PORTS*LINE_SIZE-1:0] wdata_i;
  logic [NUM_PORTS-1:0]           ack_o;
  logic [NUM_PORTS-1:0]           err_o;
  logic [LINE_SIZE-1:0]           rdata_o;
  logic                           mem_req_o;
  logic                           mem_wr_o;
  logic [ADDR_BITS-1:0]           mem_addr_o;
  logic [LINE_SIZE-1:0]           mem_wdata_o;
  logic [LINE_SIZE-1:0]           mem_rdata_i;
  logic                           mem_ack_i;
  logic                           busy_o;

  modport slave (
    input  req_i, wr_i, addr_i, wdata_i, mem_rdata_i, mem_ack_i,
    output ack_o, err_o, rdata_o, mem_req_o, mem_wr_o, mem_addr_o, mem_wdata_o, busy_o
  );

  modport master (
    output req_i, wr_i, addr_i, wdata_i, mem_rdata_i, mem_ack_i,
    input  ack_o, err_o, rdata_o, mem_req_o, mem_wr_o, mem_addr_o, mem_wdata_o, busy_o
  );
endinterface

// File: rtl/line_bus_arbiter.sv
// Round-robin arbiter sequencing whole-line read/write transactions onto one memory bus.
// Latency: request -> mem_req_o next cycle; mem_ack_i -> ack_o next cycle (2 cycles minimum).
// Backpressure: req_i held until ack_o, memory stalls via mem_ack_i; BUS_TIMEOUT_EN adds an abort watchdog.
module line_bus_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_BITS = 16,
  parameter int LINE_SIZE = 256,
  parameter int TIMEOUT   = 64
) (
  input logic       clk,
  input logic       reset,
  line_bus_if.slave bus
);
  localparam int PW = $clog2(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_num_ports
    $error("line_bus_arbiter: NUM_PORTS must be 2..8");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("line_bus_arbiter: TIMEOUT must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  state_t                state;
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         grant;
  logic [PW-1:0]         win_idx;
  logic [PW-1:0]         cand_idx;
  logic                  win_vld;
  int                    cand;
  logic [ADDR_BITS-1:0]  addr_arr  [NUM_PORTS];
  logic [LINE_SIZE-1:0]  wdata_arr [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign addr_arr[p]  = bus.addr_i[p*ADDR_BITS +: ADDR_BITS];
    assign wdata_arr[p] = bus.wdata_i[p*LINE_SIZE +: LINE_SIZE];
  end

  // Walk offsets from the far end down so the requester closest above ptr wins.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      cand_idx = PW'(cand);
      if (bus.req_i[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] tmo_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      ptr             <= '0;
      grant           <= '0;
      bus.ack_o       <= '0;
      bus.err_o       <= '0;
      bus.rdata_o     <= '0;
      bus.mem_req_o   <= 1'b0;
      bus.mem_wr_o    <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
      bus.busy_o      <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt         <= '0;
`endif
    end else begin
      bus.ack_o <= '0;
      bus.err_o <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            grant           <= win_idx;
            bus.mem_wr_o    <= bus.wr_i[win_idx];
            bus.mem_addr_o  <= addr_arr[win_idx];
            bus.mem_wdata_o <= wdata_arr[win_idx];
            bus.mem_req_o   <= 1'b1;
            bus.busy_o      <= 1'b1;
            state           <= MEM;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt         <= '0;
`endif
          end
        end
        MEM: begin
          // A memory ack on the limit cycle wins over the watchdog.
          if (bus.mem_ack_i) begin
            if (!bus.mem_wr_o) bus.rdata_o <= bus.mem_rdata_i;
            bus.ack_o[grant] <= 1'b1;
            bus.mem_req_o    <= 1'b0;
            state            <= RESP;
          end
`ifdef BUS_TIMEOUT_EN
          else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
            bus.rdata_o      <= '0;
            bus.ack_o[grant] <= 1'b1;
            bus.err_o[grant] <= 1'b1;
            bus.mem_req_o    <= 1'b0;
            state            <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          ptr        <= (grant == PW'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
          bus.busy_o <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_bus_arbiter.sv
// Directed bench for line_bus_arbiter: table-driven single transactions plus hand-written
// sequences for spurious acks, mid-transaction reset, round-robin rotation and the watchdog.
`timescale 1ns/1ps
module tb_line_bus_arbiter;
  localparam int NP = 4;
  localparam int AB = 16;
  localparam int LS = 256;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  line_bus_if #(.NUM_PORTS(NP), .ADDR_BITS(AB), .LINE_SIZE(LS)) bus();

  line_bus_arbiter #(
    .NUM_PORTS(NP), .ADDR_BITS(AB), .LINE_SIZE(LS), .TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    int            port;
    logic          wr;
    logic [AB-1:0] addr;
    logic [LS-1:0] wdata;
    int            delay;
    logic [LS-1:0] mrdata;
    logic [NP-1:0] exp_ack;
    logic [LS-1:0] exp_rdata;
    int            exp_cyc;
  } vec_t;

  vec_t vecs[5];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [LS-1:0] act, input logic [LS-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic wr, input logic [AB-1:0] addr,
                          input logic [LS-1:0] wdata);
    bus.wr_i[p]             = wr;
    bus.addr_i[p*AB +: AB]  = addr;
    bus.wdata_i[p*LS +: LS] = wdata;
  endtask

  task automatic mem_ack_pulse(input logic [LS-1:0] rd);
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = rd;
    tick();
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = ~rd;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int start;
    int n;
    start = cyc;
    set_port(v.port, v.wr, v.addr, v.wdata);
    bus.req_i[v.port] = 1'b1;
    tick();
    check({tag, "_mem_req"}, LS'(bus.mem_req_o), LS'(1'b1));
    check({tag, "_mem_wr"}, LS'(bus.mem_wr_o), LS'(v.wr));
    check({tag, "_busy"}, LS'(bus.busy_o), LS'(1'b1));
    if (v.wr) check({tag, "_mem_wdata"}, bus.mem_wdata_o, v.wdata);
    set_port(v.port, ~v.wr, ~v.addr, ~v.wdata);
    repeat (v.delay) tick();
    check({tag, "_addr_held"}, LS'(bus.mem_addr_o), LS'(v.addr));
    mem_ack_pulse(v.mrdata);
    n = 0;
    while (bus.ack_o == '0 && n < 4) begin
      tick();
      n++;
    end
    check({tag, "_ack_cycle"}, LS'(cyc - start), LS'(v.exp_cyc));
    check({tag, "_ack"}, LS'(bus.ack_o), LS'(v.exp_ack));
    check({tag, "_err"}, LS'(bus.err_o), '0);
    check({tag, "_rdata"}, bus.rdata_o, v.exp_rdata);
    check({tag, "_mem_req_low"}, LS'(bus.mem_req_o), '0);
    bus.req_i[v.port] = 1'b0;
    tick();
    check({tag, "_ack_one_cycle"}, LS'(bus.ack_o), '0);
    check({tag, "_idle_busy"}, LS'(bus.busy_o), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NP-1:0] rr_ack [5];
    logic [AB-1:0] rr_addr [5];
    int start;
    int n;

    vecs[0] = '{1, 1'b0, 16'h0040, {LS{1'b0}}, 3, {8{32'hA5A5A5A5}},
                4'b0010, {8{32'hA5A5A5A5}}, 5};
    vecs[1] = '{0, 1'b1, 16'h1234, {16{16'h1234}}, 0, {8{32'h0BADF00D}},
                4'b0001, {8{32'hA5A5A5A5}}, 2};
    vecs[2] = '{3, 1'b0, 16'hFFFF, {LS{1'b0}}, 1, {8{32'h5A5A5A5A}},
                4'b1000, {8{32'h5A5A5A5A}}, 3};
    vecs[3] = '{2, 1'b1, 16'h0000, {8{32'hCAFEF00D}}, 2, {8{32'h11111111}},
                4'b0100, {8{32'h5A5A5A5A}}, 4};
    vecs[4] = '{2, 1'b0, 16'h0ABC, {LS{1'b0}}, 0, {8{32'h01234567}},
                4'b0100, {8{32'h01234567}}, 2};
    rr_ack  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_addr = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0100};

    bus.req_i = '0; bus.wr_i = '0; bus.addr_i = '0; bus.wdata_i = '0;
    bus.mem_rdata_i = '0; bus.mem_ack_i = 1'b0;

    tick();
    tick();
    check("rst_ack", LS'(bus.ack_o), '0);
    check("rst_err", LS'(bus.err_o), '0);
    check("rst_rdata", bus.rdata_o, '0);
    check("rst_mem_req", LS'(bus.mem_req_o), '0);
    check("rst_mem_wr", LS'(bus.mem_wr_o), '0);
    check("rst_mem_addr", LS'(bus.mem_addr_o), '0);
    check("rst_mem_wdata", bus.mem_wdata_o, '0);
    check("rst_busy", LS'(bus.busy_o), '0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Memory ack while idle must not complete anything.
    mem_ack_pulse({LS{1'b1}});
    check("spur_ack", LS'(bus.ack_o), '0);
    check("spur_mem_req", LS'(bus.mem_req_o), '0);
    check("spur_rdata", bus.rdata_o, {8{32'h01234567}});
    tick();
    check("spur_busy", LS'(bus.busy_o), '0);

    // ptr is 3 here: port 3 wins first, then reset returns ptr to 0 so port 1 wins.
    set_port(1, 1'b0, 16'h0111, {LS{1'b0}});
    set_port(3, 1'b1, 16'h0333, {8{32'hDEADBEEF}});
    bus.req_i = 4'b1010;
    tick();
    check("pre_rst_grant", LS'(bus.mem_addr_o), LS'(16'h0333));
    reset = 1'b1;
    tick();
    check("mid_rst_ack", LS'(bus.ack_o), '0);
    check("mid_rst_mem_req", LS'(bus.mem_req_o), '0);
    check("mid_rst_mem_wr", LS'(bus.mem_wr_o), '0);
    check("mid_rst_mem_addr", LS'(bus.mem_addr_o), '0);
    check("mid_rst_mem_wdata", bus.mem_wdata_o, '0);
    check("mid_rst_rdata", bus.rdata_o, '0);
    check("mid_rst_busy", LS'(bus.busy_o), '0);
    reset = 1'b0;
    tick();
    check("post_rst_req", LS'(bus.mem_req_o), LS'(1'b1));
    check("post_rst_grant", LS'(bus.mem_addr_o), LS'(16'h0111));
    mem_ack_pulse({8{32'h77777777}});
    check("post_rst_ack1", LS'(bus.ack_o), LS'(4'b0010));
    check("post_rst_rdata", bus.rdata_o, {8{32'h77777777}});
    bus.req_i[1] = 1'b0;
    tick();
    tick();
    check("post_rst_grant3", LS'(bus.mem_addr_o), LS'(16'h0333));
    mem_ack_pulse({LS{1'b0}});
    check("post_rst_ack3", LS'(bus.ack_o), LS'(4'b1000));
    check("post_rst_wr_rdata", bus.rdata_o, {8{32'h77777777}});
    bus.req_i[3] = 1'b0;
    tick();

    // All ports requesting continuously, ptr back at 0.
    for (int p = 0; p < NP; p++) set_port(p, 1'b0, AB'(16'h0100 + p), {LS{1'b0}});
    bus.req_i = 4'b1111;
    start = cyc;
    tick();
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (!bus.mem_req_o && n < 8) begin
        tick();
        n++;
      end
      check($sformatf("rr%0d_start", k), LS'(cyc - start), LS'(1 + 3*k));
      check($sformatf("rr%0d_grant", k), LS'(bus.mem_addr_o), LS'(rr_addr[k]));
      mem_ack_pulse({LS{1'b0}});
      check($sformatf("rr%0d_ack", k), LS'(bus.ack_o), LS'(rr_ack[k]));
      if (k == 4) bus.req_i = '0;
      tick();
    end
    tick();

    set_port(0, 1'b0, 16'h0AAA, {LS{1'b0}});
    bus.req_i[0] = 1'b1;
    start = cyc;
    tick();
`ifdef BUS_TIMEOUT_EN
    n = 0;
    while (bus.ack_o == '0 && n < 20) begin
      tick();
      n++;
    end
    check("tmo_cycle", LS'(cyc - start), LS'(9));
    check("tmo_ack", LS'(bus.ack_o), LS'(4'b0001));
    check("tmo_err", LS'(bus.err_o), LS'(4'b0001));
    check("tmo_rdata", bus.rdata_o, '0);
    check("tmo_mem_req", LS'(bus.mem_req_o), '0);
    bus.req_i[0] = 1'b0;
    tick();
    check("tmo_err_one_cycle", LS'(bus.err_o), '0);
    bus.req_i[0] = 1'b1;
    tick();
    repeat (7) tick();
    mem_ack_pulse({8{32'h3C3C3C3C}});
    check("late_ack", LS'(bus.ack_o), LS'(4'b0001));
    check("late_err", LS'(bus.err_o), '0);
    check("late_rdata", bus.rdata_o, {8{32'h3C3C3C3C}});
`else
    repeat (20) tick();
    check("wait_mem_req", LS'(bus.mem_req_o), LS'(1'b1));
    check("wait_no_ack", LS'(bus.ack_o), '0);
    mem_ack_pulse({8{32'h3C3C3C3C}});
    check("wait_ack", LS'(bus.ack_o), LS'(4'b0001));
    check("wait_err", LS'(bus.err_o), '0);
    check("wait_rdata", bus.rdata_o, {8{32'h3C3C3C3C}});
`endif
    bus.req_i = '0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
